// File: rtl/scan_seq_bank_if.sv
// Handshake/data bundle for the scan-accessible sequential state bank.
// The master drives mode and data; the slave (the bank) returns state views.
interface scan_seq_bank_if #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNTW  = 6
);
    logic [1:0]           mode;
    logic [NCH*WIDTH-1:0] din;
    logic [NCH-1:0]       oen;
    logic                 si;
    logic                 so;
    logic [NCH*WIDTH-1:0] dout;
    logic [WIDTH-1:0]     sig;
    logic [CNTW-1:0]      scan_cnt;
    logic                 scan_done;

    modport master (
        output mode, din, oen, si,
        input  so, dout, sig, scan_cnt, scan_done
    );

    modport slave (
        input  mode, din, oen, si,
        output so, dout, sig, scan_cnt, scan_done
    );
endinterface

// File: rtl/scan_seq_bank.sv
// NCH x WIDTH state bank with hold, coupled functional update, full-chain scan
// shift and MISR signature capture; outputs gated per channel by oen.
module scan_seq_bank #(
    parameter int unsigned     NCH   = 4,
    parameter int unsigned     WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY = 8'h1D,
    parameter int unsigned     CNTW  = 6
) (
    input logic            clk,
    input logic            rst,
    scan_seq_bank_if.slave bus
);
    localparam int unsigned N = NCH * WIDTH;

    typedef enum logic [1:0] {
        ModeHold = 2'b00,
        ModeFunc = 2'b01,
        ModeScan = 2'b10,
        ModeMisr = 2'b11
    } mode_e;

    mode_e            mode;
    logic [N-1:0]     state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] fold;
    logic [WIDTH-1:0] cur;
    logic             cin;
    logic [N-1:0]     dout_w;

    assign mode = mode_e'(bus.mode);

    always_comb begin
        fold = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            fold = fold ^ bus.din[c*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = '0;
        done_d  = 1'b0;
        cur     = '0;
        cin     = 1'b0;
        unique case (mode)
            ModeHold: ;
            ModeFunc: begin
                // Coupling reads the pre-edge MSB of the previous channel (ring order).
                for (int unsigned c = 0; c < NCH; c++) begin
                    cur = state_q[c*WIDTH +: WIDTH];
                    cin = state_q[((c + NCH - 1) % NCH) * WIDTH + WIDTH - 1];
                    state_d[c*WIDTH +: WIDTH] = {cur[WIDTH-2:0], cur[WIDTH-1]}
                                              ^ bus.din[c*WIDTH +: WIDTH]
                                              ^ {{(WIDTH-1){1'b0}}, cin};
                end
            end
            ModeScan: begin
                state_d = {state_q[N-2:0], bus.si};
                if (cnt_q == CNTW'(N - 1)) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            ModeMisr: begin
                sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ fold;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            sig_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        dout_w = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            dout_w[c*WIDTH +: WIDTH] = state_q[c*WIDTH +: WIDTH] & {WIDTH{bus.oen[c]}};
        end
    end

    assign bus.so        = state_q[N-1];
    assign bus.dout      = dout_w;
    assign bus.sig       = sig_q;
    assign bus.scan_cnt  = cnt_q;
    assign bus.scan_done = done_q;
endmodule

// File: tb/tb_scan_seq_bank.sv
// Directed bench for scan_seq_bank: reset, scan wrap, coupled FUNC, MISR,
// output gating, scan abort and asynchronous reset mid-scan.
module tb_scan_seq_bank;
    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    scan_seq_bank_if bus ();

    scan_seq_bank dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scan_load(input logic [31:0] v);
        bus.mode = 2'b10;
        for (int i = 31; i >= 0; i--) begin
            bus.si = v[i];
            tick();
        end
    endtask

    initial begin
        rst      = 1'b1;
        bus.mode = 2'b00;
        bus.din  = '0;
        bus.oen  = 4'hF;
        bus.si   = 1'b0;
        #1;
        check("rst_dout", bus.dout, 32'h0);
        check("rst_so", 32'(bus.so), 32'h0);
        check("rst_sig", 32'(bus.sig), 32'h0);
        check("rst_cnt", 32'(bus.scan_cnt), 32'h0);
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("hold_after_rst_dout", bus.dout, 32'h0);

        // Full chain of ones, then flush with zeros
        bus.mode = 2'b10;
        bus.si   = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            check("scan1_cnt", 32'(bus.scan_cnt), (i == 32) ? 32'd0 : 32'(i));
            check("scan1_done", 32'(bus.scan_done), (i == 32) ? 32'd1 : 32'd0);
        end
        check("scan1_state", bus.dout, 32'hFFFF_FFFF);
        bus.si = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            check("scan2_so", 32'(bus.so), 32'd1);
            tick();
            if (i == 1) check("scan2_done_drop", 32'(bus.scan_done), 32'd0);
        end
        check("scan2_so_end", 32'(bus.so), 32'd0);
        check("scan2_done", 32'(bus.scan_done), 32'd1);
        check("scan2_state", bus.dout, 32'h0);

        // FUNC update and ring coupling
        bus.mode = 2'b01;
        bus.din  = 32'h0000_0001;
        tick();
        check("func1", bus.dout, 32'h0000_0001);
        check("func1_cnt", 32'(bus.scan_cnt), 32'd0);
        check("func1_done", 32'(bus.scan_done), 32'd0);
        bus.din = '0;
        tick();
        check("func2", bus.dout, 32'h0000_0002);
        scan_load(32'h8000_0000);
        check("func_preload", bus.dout, 32'h8000_0000);
        bus.mode = 2'b01;
        tick();
        check("func_couple", bus.dout, 32'h0100_0001);

        // MISR
        bus.mode = 2'b11;
        bus.din  = 32'h0000_0080;
        tick();
        check("misr1", 32'(bus.sig), 32'h80);
        bus.din = '0;
        tick();
        check("misr2", 32'(bus.sig), 32'h1D);
        tick();
        check("misr3", 32'(bus.sig), 32'h3A);
        bus.din = 32'h0102_0408;
        tick();
        check("misr_fold", 32'(bus.sig), 32'h7B);
        check("misr_state_hold", bus.dout, 32'h0100_0001);
        bus.din = '0;

        // Output gating
        scan_load(32'hA5A5_A5A5);
        bus.mode = 2'b00;
        bus.oen  = 4'b0101;
        tick();
        check("gate_0101", bus.dout, 32'h00A5_00A5);
        #2;
        bus.oen = 4'b1010;
        #1;
        check("gate_1010", bus.dout, 32'hA500_A500);
        bus.oen = 4'hF;
        #1;
        check("gate_all", bus.dout, 32'hA5A5_A5A5);
        check("sig_hold", 32'(bus.sig), 32'h7B);

        // Scan abort restarts the count
        tick();
        bus.mode = 2'b10;
        bus.si   = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("abort_cnt10", 32'(bus.scan_cnt), 32'd10);
        bus.mode = 2'b00;
        tick();
        check("abort_cnt_clr", 32'(bus.scan_cnt), 32'd0);
        check("abort_done0", 32'(bus.scan_done), 32'd0);
        bus.mode = 2'b10;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 22) check("abort_cnt22", 32'(bus.scan_cnt), 32'd22);
            if (i < 32) check("abort_done_lo", 32'(bus.scan_done), 32'd0);
            else begin
                check("abort_done_hi", 32'(bus.scan_done), 32'd1);
                check("abort_cnt_wrap", 32'(bus.scan_cnt), 32'd0);
            end
        end

        // Asynchronous reset mid-scan
        scan_load(32'h3C5A_96E1);
        bus.si = 1'b1;
        tick();
        tick();
        tick();
        check("pre_rst_state", bus.dout, 32'hE2D4_B70F);
        check("pre_rst_cnt", 32'(bus.scan_cnt), 32'd3);
        check("pre_rst_so", 32'(bus.so), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_dout", bus.dout, 32'h0);
        check("arst_so", 32'(bus.so), 32'h0);
        check("arst_sig", 32'(bus.sig), 32'h0);
        check("arst_cnt", 32'(bus.scan_cnt), 32'h0);
        check("arst_done", 32'(bus.scan_done), 32'h0);
        bus.mode = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_done", 32'(bus.scan_done), 32'h0);
        check("post_rst_dout", bus.dout, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
